// File: rtl/cla_pipe_addsub_pkg.sv
// Shared ALU definitions for the pipelined carry-lookahead adder/subtractor.
package cla_pipe_addsub_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int CLA_GROUP_W = 4;

  typedef struct packed {
    logic co;
    logic ovf;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/cla_pipe_addsub_group4.sv
// Combinational 4-bit carry-lookahead group; c3 is exposed so the top can derive signed overflow.
module cla_group4
  import cla_pipe_addsub_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   ci,
  output logic [CLA_GROUP_W-1:0] sum,
  output logic                   co,
  output logic                   c3
);

  logic [CLA_GROUP_W-1:0] g;
  logic [CLA_GROUP_W-1:0] p;
  logic                   c1;
  logic                   c2;

  assign g  = a & b;
  assign p  = a | b;
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  // Propagate is a|b for the lookahead terms, so the sum uses a^b directly.
  assign sum = a ^ b ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: each stage resolves GROUPS_PER_STAGE 4-bit groups
// and forwards the carry, the partial sum and the still-unresolved operand bits.
module cla_pipe_addsub
  import cla_pipe_addsub_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int GPS    = GROUPS_PER_STAGE;
  localparam int GW     = CLA_GROUP_W * GPS;
  localparam int STAGES = WIDTH / GW;
  localparam int NG     = WIDTH / CLA_GROUP_W;

  logic             adv;
  logic [WIDTH-1:0] a_src  [STAGES];
  logic [WIDTH-1:0] b_src  [STAGES];
  logic             ci_src [STAGES];
  logic [WIDTH-1:0] grp_sum;
  logic [NG-1:0]    grp_co;
  logic [NG-1:0]    grp_c3;

  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] vld_q, vld_d;
  alu_flags_t        flags_q, flags_d;

  // The whole pipe moves as one: any free slot at the output lets every stage shift.
  assign adv      = out_ready | ~vld_q[STAGES-1];
  assign in_ready = adv;

  always_comb begin
    a_src[0]  = in_a;
    b_src[0]  = (in_sub == ALU_OP_SUB) ? ~in_b : in_b;
    ci_src[0] = (in_sub == ALU_OP_SUB) ? 1'b1 : in_ci;
    for (int s = 1; s < STAGES; s++) begin
      a_src[s]  = a_q[s-1];
      b_src[s]  = b_q[s-1];
      ci_src[s] = c_q[s-1];
    end
  end

  for (genvar j = 0; j < NG; j++) begin : g_grp
    localparam int S = j / GPS;
    logic ci_w;
    logic co_w;
    if (j % GPS == 0) begin : g_head
      assign ci_w = ci_src[S];
    end else begin : g_chain
      assign ci_w = g_grp[j-1].co_w;
    end
    cla_group4 u_grp (
      .a   (a_src[S][j*CLA_GROUP_W +: CLA_GROUP_W]),
      .b   (b_src[S][j*CLA_GROUP_W +: CLA_GROUP_W]),
      .ci  (ci_w),
      .sum (grp_sum[j*CLA_GROUP_W +: CLA_GROUP_W]),
      .co  (co_w),
      .c3  (grp_c3[j])
    );
    assign grp_co[j] = co_w;
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      sum_d[s] = '0;
      vld_d[s] = in_valid;
      if (s > 0) begin
        sum_d[s] = sum_q[s-1];
        vld_d[s] = vld_q[s-1];
      end
      sum_d[s][s*GW +: GW] = grp_sum[s*GW +: GW];
      a_d[s] = a_src[s];
      b_d[s] = b_src[s];
      c_d[s] = grp_co[s*GPS + GPS - 1];
    end
    flags_d.co   = grp_co[NG-1];
    flags_d.ovf  = grp_c3[NG-1] ^ grp_co[NG-1];
    flags_d.zero = ~|sum_d[STAGES-1];
  end

  // Pipeline stage boundaries: stage k register captures groups up to k*GPS+GPS-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) begin
        sum_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
      end
      c_q     <= '0;
      vld_q   <= '0;
      flags_q <= '0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        sum_q[s] <= sum_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
      end
      c_q     <= c_d;
      vld_q   <= vld_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_co    = flags_q.co;
  assign out_ovf   = flags_q.ovf;
  assign out_zero  = flags_q.zero;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: a 4-stage instance for directed tests plus random traffic,
// and a single-stage instance for random traffic, both scored against an arithmetic model.
module tb_cla_pipe_addsub;

  localparam int STG_A = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_in_ci = 1'b0, a_in_sub = 1'b0;
  logic [15:0] a_in_a = '0, a_in_b = '0, a_out_sum;
  logic        a_out_valid, a_out_ready = 1'b1, a_out_co, a_out_ovf, a_out_zero;

  logic        b_in_valid = 1'b0, b_in_ready, b_in_ci = 1'b0, b_in_sub = 1'b0;
  logic [15:0] b_in_a = '0, b_in_b = '0, b_out_sum;
  logic        b_out_valid, b_out_ready = 1'b1, b_out_co, b_out_ovf, b_out_zero;

  int n_vec  = 0;
  int n_fail = 0;
  int na_out = 0;
  logic [18:0] qa[$];
  logic [18:0] qb[$];
  logic        b_acc_prev = 1'b0;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(16), .GROUPS_PER_STAGE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_b(a_in_b), .in_ci(a_in_ci), .in_sub(a_in_sub),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
    .out_co(a_out_co), .out_ovf(a_out_ovf), .out_zero(a_out_zero));

  cla_pipe_addsub #(.WIDTH(16), .GROUPS_PER_STAGE(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_ci(b_in_ci), .in_sub(b_in_sub),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_co(b_out_co), .out_ovf(b_out_ovf), .out_zero(b_out_zero));

  // Result packed as {co, ovf, zero, sum}, derived from integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sub);
    int          u;
    int          s;
    logic [15:0] r;
    logic        co;
    if (sub) begin
      r  = a - b;
      co = (a >= b);
      s  = int'($signed(a)) - int'($signed(b));
    end else begin
      u  = int'(a) + int'(b) + int'(ci);
      r  = u[15:0];
      co = (u > 65535);
      s  = int'($signed(a)) + int'($signed(b)) + int'(ci);
    end
    return {co, (s > 32767) || (s < -32768), (r == 16'h0000), r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every meaningful output cycle is compared against the queue head.
  always @(negedge clk) begin
    if (!reset_n) begin
      qa.delete();
      qb.delete();
      b_acc_prev = 1'b0;
      chk("rst_a_outs", {a_out_valid, a_out_co, a_out_ovf, a_out_zero, a_out_sum}, 32'h0);
      chk("rst_b_outs", {b_out_valid, b_out_co, b_out_ovf, b_out_zero, b_out_sum}, 32'h0);
      chk("rst_in_ready", {a_in_ready, b_in_ready}, 32'h3);
    end else begin
      if (a_out_valid) begin
        if (qa.size() == 0) chk("a_spurious_out", 32'h1, 32'h0);
        else begin
          chk("a_result", {a_out_co, a_out_ovf, a_out_zero, a_out_sum}, qa[0]);
          if (a_out_ready) begin
            void'(qa.pop_front());
            na_out++;
          end
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back(model(a_in_a, a_in_b, a_in_ci, a_in_sub));

      if (b_acc_prev) chk("b_latency", b_out_valid, 32'h1);
      if (b_out_valid) begin
        if (qb.size() == 0) chk("b_spurious_out", 32'h1, 32'h0);
        else begin
          chk("b_result", {b_out_co, b_out_ovf, b_out_zero, b_out_sum}, qb[0]);
          if (b_out_ready) void'(qb.pop_front());
        end
      end
      b_acc_prev = b_in_valid && b_in_ready;
      if (b_in_valid && b_in_ready) qb.push_back(model(b_in_a, b_in_b, b_in_ci, b_in_sub));
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that accepted the operands.
  task automatic issue_a(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sub);
    logic acc;
    acc = 1'b0;
    a_in_valid = 1'b1; a_in_a = a; a_in_b = b; a_in_ci = ci; a_in_sub = sub;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("issue_timeout", 32'h0, 32'h1);
    a_in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sub, input logic [18:0] exp);
    int lat;
    lat = 0;
    issue_a(a, b, ci, sub);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_out_valid) break;
      lat++;
    end
    chk({name, "_latency"}, lat, STG_A - 1);
    chk(name, {a_out_co, a_out_ovf, a_out_zero, a_out_sum}, exp);
    @(posedge clk); #1;
  endtask

  task automatic drain;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0) break;
    end
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_out;
    logic [15:0] held;

    // Pin the model with hand-computed values.
    chk("model_ffff_p1", model(16'hFFFF, 16'h0001, 1'b0, 1'b0), {3'b101, 16'h0000});
    chk("model_7fff_p1", model(16'h7FFF, 16'h0001, 1'b0, 1'b0), {3'b010, 16'h8000});
    chk("model_8000_m1", model(16'h8000, 16'h0001, 1'b1, 1'b1), {3'b110, 16'h7FFF});
    chk("model_0001_m2", model(16'h0001, 16'h0002, 1'b0, 1'b1), {3'b000, 16'hFFFF});

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    run_one("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {3'b101, 16'h0000});
    run_one("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {3'b010, 16'h8000});
    run_one("add_00ff_ci",   16'h00FF, 16'h0000, 1'b1, 1'b0, {3'b000, 16'h0100});
    run_one("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 1'b1, {3'b110, 16'h7FFF});
    run_one("sub_0001_0002", 16'h0001, 16'h0002, 1'b0, 1'b1, {3'b000, 16'hFFFF});

    // Six back-to-back accepts with a 3-cycle output stall.
    start_out = na_out;
    fork
      begin
        for (int i = 1; i <= 6; i++) issue_a(16'h1111 * i[15:0], i[15:0], 1'b0, 1'b0);
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(posedge clk); #1;
          if (a_out_valid) break;
        end
        chk("stall_valid_seen", a_out_valid, 32'h1);
        a_out_ready = 1'b0;
        held = a_out_sum;
        repeat (3) begin
          #1 chk("stall_in_ready", a_in_ready, 32'h0);
          @(posedge clk); #1;
          chk("stall_held_sum", a_out_sum, held);
          chk("stall_held_valid", a_out_valid, 32'h1);
        end
        a_out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", na_out - start_out, 6);

    // Reset with three operations in flight.
    issue_a(16'h1234, 16'h0001, 1'b0, 1'b0);
    issue_a(16'h2222, 16'h0003, 1'b0, 1'b1);
    issue_a(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1 chk("rst_mid_outs", {a_out_valid, a_out_co, a_out_ovf, a_out_zero, a_out_sum}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", a_out_valid, 32'h0);
    @(posedge clk); #1;
    run_one("post_rst_sub", 16'h5000, 16'h1234, 1'b0, 1'b1, {3'b100, 16'h3DCC});

    // Random traffic on both instances.
    fork
      begin
        int acc = 0;
        for (int c = 0; c < 8000 && acc < 1000; c++) begin
          a_in_valid  = ($urandom_range(3) != 0);
          a_in_a      = ($urandom_range(7) == 0) ? 16'h7FFF : 16'($urandom);
          a_in_b      = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
          a_in_ci     = 1'($urandom);
          a_in_sub    = 1'($urandom);
          a_out_ready = ($urandom_range(2) != 0);
          @(negedge clk);
          if (a_in_valid && a_in_ready) acc++;
          @(posedge clk); #1;
        end
        chk("rand_a_accepts", acc, 1000);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
      end
      begin
        int acc = 0;
        for (int c = 0; c < 8000 && acc < 1000; c++) begin
          b_in_valid  = ($urandom_range(3) != 0);
          b_in_a      = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
          b_in_b      = ($urandom_range(7) == 0) ? 16'h0001 : 16'($urandom);
          b_in_ci     = 1'($urandom);
          b_in_sub    = 1'($urandom);
          b_out_ready = ($urandom_range(2) != 0);
          @(negedge clk);
          if (b_in_valid && b_in_ready) acc++;
          @(posedge clk); #1;
        end
        chk("rand_b_accepts", acc, 1000);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
